// File: rtl/core_if_istr_buf.sv
// IF->ID instruction fetch buffer: FIFO of {pc, istr} pairs with valid/ready on both sides.
// Optional zero-latency empty-buffer bypass enabled by defining CORE_IF_BUF_BYPASS_EN.
module core_if_istr_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_ISTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_istr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_istr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [63:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty, full;
  logic        push, pop;
  logic [63:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign in_ready = ~full & ~rst;

`ifdef CORE_IF_BUF_BYPASS_EN
  logic bypass;

  // Empty buffer and a ready consumer: hand the input straight to ID, store nothing.
  assign bypass    = empty & in_valid & out_ready & ~flush & ~rst;
  assign out_valid = (~empty & ~flush & ~rst) | bypass;
  assign push      = in_valid & in_ready & ~flush & ~bypass;
  assign pop       = out_valid & out_ready & ~bypass;

  always_comb begin
    out_pc   = '0;
    out_istr = NOP_ISTR;
    if (bypass) begin
      out_pc   = in_pc;
      out_istr = in_istr;
    end else if (out_valid) begin
      out_pc   = head[63:32];
      out_istr = head[31:0];
    end
  end
`else
  assign out_valid = ~empty & ~flush & ~rst;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    out_pc   = '0;
    out_istr = NOP_ISTR;
    if (out_valid) begin
      out_pc   = head[63:32];
      out_istr = head[31:0];
    end
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_pc, in_istr};
  end

endmodule

// File: tb/tb_core_if_istr_buf.sv
// Self-checking bench for core_if_istr_buf against a queue-based reference model.
// Honours CORE_IF_BUF_BYPASS_EN when the design is built with it.
module tb_core_if_istr_buf;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [31:0]   in_pc, in_istr;
  logic          in_ready, out_valid;
  logic [31:0]   out_pc, out_istr;
  logic [CW-1:0] count;

  core_if_istr_buf #(.DEPTH(DEPTH), .NOP_ISTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_istr(in_istr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_istr(out_istr),
    .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0]   q[$];
  logic          e_in_ready, e_out_valid, m_push, m_pop;
  logic [31:0]   e_pc, e_istr;
  logic [CW-1:0] e_count;
  logic [CW+65:0] obs, exp_v;

`ifdef CORE_IF_BUF_BYPASS_EN
  localparam int unsigned STREAM_CNT = 0;
`else
  localparam int unsigned STREAM_CNT = 1;
`endif

  // Expected outputs from the queue contents and current inputs.
  task automatic model_eval();
    e_count     = CW'(q.size());
    e_in_ready  = !rst && (q.size() < DEPTH);
    e_out_valid = !rst && !flush && (q.size() > 0);
    e_pc        = '0;
    e_istr      = NOP;
    if (e_out_valid) begin
      e_pc   = q[0][63:32];
      e_istr = q[0][31:0];
    end
    m_push = in_valid && e_in_ready && !flush;
    m_pop  = e_out_valid && out_ready;
`ifdef CORE_IF_BUF_BYPASS_EN
    if (!rst && !flush && q.size() == 0 && in_valid && out_ready) begin
      e_out_valid = 1'b1;
      e_pc        = in_pc;
      e_istr      = in_istr;
      m_push      = 1'b0;
      m_pop       = 1'b0;
    end
`endif
    exp_v = {e_in_ready, e_out_valid, e_pc, e_istr, e_count};
    obs   = {in_ready, out_valid, out_pc, out_istr, count};
  endtask

  task automatic model_tick();
    if (rst || flush) q.delete();
    else begin
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back({in_pc, in_istr});
    end
  endtask

  task automatic settle();
    #3;
    model_eval();
  endtask

  task automatic clock();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] pc);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_pc     = pc;
    in_istr   = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h40 + 32'(i) * 4);
      settle();
      total++;
      if ({in_ready, out_valid, out_pc, out_istr} !== {1'b0, 1'b0, 32'h0, NOP}) begin
        bad++;
        $display("FAIL reset[%0d] got rdy=%b vld=%b pc=%h istr=%h exp 0 0 0 %h",
                 i, in_ready, out_valid, out_pc, out_istr, NOP);
      end
      clock();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    total++;
    if (obs !== exp_v || count !== '0) begin
      bad++;
      $display("FAIL reset_release got %h exp %h (count %0d)", obs, exp_v, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i) * 4);
      settle();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL fill[%0d] got %h exp %h", i, obs, exp_v);
      end
      clock();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    total++;
    if (count !== CW'(4) || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full got count=%0d rdy=%b exp count=4 rdy=0", count, in_ready);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      settle();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL drain[%0d] got %h exp %h", i, obs, exp_v);
      end
      if (i < 4) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(i) * 4) begin
          bad++;
          $display("FAIL drain_pc[%0d] got vld=%b pc=%h exp 1 %h", i, out_valid, out_pc, 32'h100 + 32'(i) * 4);
        end
      end
      clock();
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i) * 4);
      settle();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL stream[%0d] got %h exp %h", i, obs, exp_v);
      end
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || count !== CW'(STREAM_CNT)) begin
          bad++;
          $display("FAIL stream_steady[%0d] got vld=%b count=%0d exp 1 %0d", i, out_valid, count, STREAM_CNT);
        end
      end
      clock();
    end
    // Let the remaining entry drain out.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      settle();
      clock();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h300 + 32'(i) * 4);
      settle();
      clock();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h200);
    settle();
    total++;
    if (obs !== exp_v || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle got %h exp %h", obs, exp_v);
    end
    clock();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      settle();
      total++;
      if (obs !== exp_v || count !== '0 || out_valid !== 1'b0 || out_pc === 32'h200) begin
        bad++;
        $display("FAIL flush_after[%0d] got %h exp %h", i, obs, exp_v);
      end
      clock();
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, (i % 3) != 0, 1'b0, 32'h500 + 32'(i) * 4);
      settle();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL wrap[%0d] got %h exp %h", i, obs, exp_v);
      end
      clock();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      settle();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL wrap_drain[%0d] got %h exp %h", i, obs, exp_v);
      end
      clock();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 5, $urandom);
      settle();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL random[%0d] got %h exp %h", i, obs, exp_v);
      end
      clock();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    test_reset();
    clock();
    test_fill();
    clock();
    test_drain();
    test_streaming();
    test_flush();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
